dispatch_unit: RTL and testbench
================================

DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning): QDEPTH, 4, instruction-buffer entries, power of 2, at least 2; N_CDB, 2, CDB channels; ROB_ID_W, 4, tag width, tag 0 = no dependency.
REQ-002 SHALL use clock clk and reset rst, synchronous, active-high.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misbranch flush
- if_valid  in  1  fetcher offers an instruction
- if_ready  out  1  unit accepts the offered instruction
- if_inst  in  32  instruction
- if_pc  in  32  instruction PC
- if_pred  in  1  predicted-taken flag
- if_rb_pc  in  32  rollback PC
- rob_full  in  1  ROB cannot accept
- rs_full  in  1  reservation station cannot accept
- lsb_full  in  1  load/store buffer cannot accept
- rob_free_id  in  ROB_ID_W  tag for the next dispatch
- rs1_q  out  5  register-file read index 1
- rs2_q  out  5  register-file read index 2
- reg_v1  in  32  register value 1
- reg_v2  in  32  register value 2
- reg_q1  in  ROB_ID_W  register rename tag 1
- reg_q2  in  ROB_ID_W  register rename tag 2
- rob_q1  out  ROB_ID_W  ROB query tag 1 (equals reg_q1)
- rob_q2  out  ROB_ID_W  ROB query tag 2 (equals reg_q2)
- rob_rdy1  in  1  ROB entry for query 1 is complete
- rob_rdy2  in  1  ROB entry for query 2 is complete
- rob_v1  in  32  ROB result for query 1
- rob_v2  in  32  ROB result for query 2
- cdb_valid  in  N_CDB  per-channel valid
- cdb_id  in  N_CDB*ROB_ID_W  per-channel tag
- cdb_data  in  N_CDB*32  per-channel result
- rob_ena  out  1  allocate ROB entry
- rob_rd  out  5  destination register
- rob_jump  out  1  instruction is a branch or jump
- rob_store  out  1  instruction is a store
- rob_pred  out  1  predicted-taken flag
- rob_pc  out  32  instruction PC
- rob_rb_pc  out  32  rollback PC
- reg_ena  out  1  rename the destination register
- rs_ena  out  1  issue to the reservation station
- lsb_ena  out  1  issue to the load/store buffer
- iss_op  out  6  opcode enum
- iss_v1  out  32  operand value 1
- iss_v2  out  32  operand value 2
- iss_q1  out  ROB_ID_W  operand tag 1
- iss_q2  out  ROB_ID_W  operand tag 2
- iss_imm  out  32  immediate
- iss_pc  out  32  instruction PC
- iss_tag  out  ROB_ID_W  destination tag; also the rename tag

Function
REQ-004 SHALL buffer fetched instructions in a circular FIFO of QDEPTH entries; pointers wrap modulo QDEPTH.
REQ-005 SHALL drive if_ready = (count < QDEPTH) && !flush; enqueue on if_valid && if_ready; no full-cycle bypass.
REQ-006 SHALL decode the head entry combinationally; rs1_q/rs2_q follow the head.
REQ-007 SHALL dispatch the head when all of these hold: FIFO non-empty, rdy, !flush, !rob_full, and the target unit is not full (LB..SW go to the LSB, all others to the RS).
- When the head cannot dispatch, it stays in place, which stalls the queue.
REQ-008 SHALL register all outputs; each ena is a single-cycle pulse in the cycle after the dispatch edge; minimum fetch-handshake-to-ena latency is 2 edges.
REQ-009 SHALL assert at most one of rs_ena/lsb_ena per dispatch; rob_ena accompanies every dispatch; reg_ena = rob_ena && rd != 0.
REQ-010 SHALL pop NOP-decoded heads without asserting any ena.
REQ-011 SHALL resolve each operand at dispatch with this priority:
- reg tag 0 gives the reg value and Q = 0;
- else the lowest-index matching CDB channel gives its data and Q = 0;
- else rob_rdy gives the ROB value and Q = 0;
- else V = 0 and Q = reg tag.
REQ-012 SHALL, on flush, clear the FIFO and deassert every ena at that edge.
- flush has priority over enqueue and dispatch.
REQ-013 SHALL, with rdy low, hold the FIFO, counters and all outputs unchanged.
REQ-014 SHALL allow enqueue and dispatch at the same edge; count is then unchanged.

Reset
REQ-015 SHALL, while rst is high, empty the FIFO and drive all ena outputs low.
- All payload outputs reset to 0; iss_op resets to NOP.
- Reset mid-stream discards buffered instructions.

Configuration
REQ-016 SHALL implement CDB bypass (REQ-011, CDB step) only when DISPATCH_CDB_BYPASS_EN is defined.
- Without it: no CDB compare; when any valid CDB tag equals a non-zero head source tag, dispatch stalls one cycle and the ROB value is taken next cycle.

Structure
REQ-017 SHALL take the opcode enum, ZERO_ROB, ZERO_WORD and NOP from the shared constants header.
REQ-018 SHALL reuse the existing decoder and instance one new sub-module, operand_forward (per-operand priority mux), twice.

Verification
REQ-019 Bench SHALL cover:
- ADDI x1,x0,5 enqueued, queues empty: rs_ena=1 and reg_ena=1 two edges later; iss_q1=0, iss_imm=5, iss_tag=rob_free_id.
- Five back-to-back fetches with rs_full=1 and QDEPTH=4: if_ready drops after 4 accepts; release rs_full: 4 consecutive rs_ena pulses in order.
- reg_q1=3 with cdb_valid=2'b11, both channels tagged 3, data A/B: iss_v1=A, iss_q1=0 (with macro); without macro: one-cycle stall, then rob_v1 is used.
- LW head with lsb_full=1, then flush: FIFO empties, no lsb_ena; the next fetch dispatches normally.
- rd=0 instruction (SW): rob_ena=1, reg_ena=0, rob_store=1; rdy low for 3 cycles mid-stream: outputs and count frozen.

Source files
------------

// File: rtl/dispatch_unit_pkg.sv
// Shared constants, opcode enum and the RV32I instruction decoder used by dispatch.
package dispatch_unit_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam int          ZERO_ROB  = 0;

  // LB..SW must stay contiguous: the LSB routing test is a range compare.
  typedef enum logic [5:0] {
    NOP, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use1;
    logic        use2;
  } dec_t;

  localparam dec_t DEC_NOP = '{op: NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                               imm: ZERO_WORD, use1: 1'b0, use2: 1'b0};

  function automatic logic is_lsb_op(input op_t op);
    return (op >= LB) && (op <= SW);
  endfunction

  function automatic logic is_store_op(input op_t op);
    return (op >= SB) && (op <= SW);
  endfunction

  function automatic logic is_jump_op(input op_t op);
    return (op >= JAL) && (op <= BGEU);
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t        d;
    logic [31:0] imm_i;
    d     = DEC_NOP;
    imm_i = {{20{inst[31]}}, inst[31:20]};
    case (inst[6:0])
      7'b0110111: begin d.op = LUI;   d.rd = inst[11:7]; d.imm = {inst[31:12], 12'b0}; end
      7'b0010111: begin d.op = AUIPC; d.rd = inst[11:7]; d.imm = {inst[31:12], 12'b0}; end
      7'b1101111: begin
        d.op  = JAL;
        d.rd  = inst[11:7];
        d.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b1100111: begin
        d.op = JALR; d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.use1 = 1'b1; d.imm = imm_i;
      end
      7'b1100011: begin
        case (inst[14:12])
          3'b000:  d.op = BEQ;
          3'b001:  d.op = BNE;
          3'b100:  d.op = BLT;
          3'b101:  d.op = BGE;
          3'b110:  d.op = BLTU;
          3'b111:  d.op = BGEU;
          default: d.op = NOP;
        endcase
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.use1 = 1'b1; d.use2 = 1'b1;
        d.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0000011: begin
        case (inst[14:12])
          3'b000:  d.op = LB;
          3'b001:  d.op = LH;
          3'b010:  d.op = LW;
          3'b100:  d.op = LBU;
          3'b101:  d.op = LHU;
          default: d.op = NOP;
        endcase
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.use1 = 1'b1; d.imm = imm_i;
      end
      7'b0100011: begin
        case (inst[14:12])
          3'b000:  d.op = SB;
          3'b001:  d.op = SH;
          3'b010:  d.op = SW;
          default: d.op = NOP;
        endcase
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.use1 = 1'b1; d.use2 = 1'b1;
        d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b0010011: begin
        case (inst[14:12])
          3'b000:  d.op = ADDI;
          3'b010:  d.op = SLTI;
          3'b011:  d.op = SLTIU;
          3'b100:  d.op = XORI;
          3'b110:  d.op = ORI;
          3'b111:  d.op = ANDI;
          3'b001:  d.op = SLLI;
          default: d.op = inst[30] ? SRAI : SRLI;
        endcase
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.use1 = 1'b1;
        d.imm = (inst[13:12] == 2'b01) ? {27'b0, inst[24:20]} : imm_i;
      end
      7'b0110011: begin
        case (inst[14:12])
          3'b000:  d.op = inst[30] ? SUB : ADD;
          3'b001:  d.op = SLL;
          3'b010:  d.op = SLT;
          3'b011:  d.op = SLTU;
          3'b100:  d.op = XOR;
          3'b101:  d.op = inst[30] ? SRA : SRL;
          3'b110:  d.op = OR;
          default: d.op = AND;
        endcase
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
        d.use1 = 1'b1; d.use2 = 1'b1;
      end
      default: d = DEC_NOP;
    endcase
    if (d.op == NOP) d = DEC_NOP;
    return d;
  endfunction

endpackage

// File: rtl/dispatch_unit_forward.sv
// operand_forward: per-operand priority mux (reg value, CDB, ROB, else rename tag).
// CDB data is only selected when DISPATCH_CDB_BYPASS_EN is defined; otherwise cdb_hit asks for a stall.
module operand_forward
  import dispatch_unit_pkg::*;
#(
  parameter int N_CDB    = 2,
  parameter int ROB_ID_W = 4
) (
  input  logic                      use_src,
  input  logic [ROB_ID_W-1:0]       reg_q,
  input  logic [31:0]               reg_v,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*ROB_ID_W-1:0] cdb_id,
  input  logic [N_CDB*32-1:0]       cdb_data,
  input  logic                      rob_rdy,
  input  logic [31:0]               rob_v,
  output logic [31:0]               v,
  output logic [ROB_ID_W-1:0]       q,
  output logic                      cdb_hit
);

  logic        match;
  logic [31:0] hit_data;

  // Descending scan so the lowest-index matching channel wins.
  always_comb begin
    match    = 1'b0;
    hit_data = ZERO_WORD;
    for (int i = N_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (cdb_id[i*ROB_ID_W +: ROB_ID_W] == reg_q)) begin
        match    = 1'b1;
        hit_data = cdb_data[i*32 +: 32];
      end
    end
  end

  assign cdb_hit = use_src && (reg_q != ROB_ID_W'(ZERO_ROB)) && match;

  always_comb begin
    v = ZERO_WORD;
    q = ROB_ID_W'(ZERO_ROB);
    if (!use_src) begin
      v = ZERO_WORD;
    end else if (reg_q == ROB_ID_W'(ZERO_ROB)) begin
      v = reg_v;
`ifdef DISPATCH_CDB_BYPASS_EN
    end else if (match) begin
      v = hit_data;
`endif
    end else if (rob_rdy) begin
      v = rob_v;
    end else begin
      q = reg_q;
    end
  end

`ifndef DISPATCH_CDB_BYPASS_EN
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
`endif

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch unit: instruction FIFO, head decode, operand resolution and registered issue outputs.
// Optional CDB bypass is enabled by defining DISPATCH_CDB_BYPASS_EN.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int QDEPTH   = 4,
  parameter int N_CDB    = 2,
  parameter int ROB_ID_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [31:0]               if_inst,
  input  logic [31:0]               if_pc,
  input  logic                      if_pred,
  input  logic [31:0]               if_rb_pc,
  input  logic                      rob_full,
  input  logic                      rs_full,
  input  logic                      lsb_full,
  input  logic [ROB_ID_W-1:0]       rob_free_id,
  output logic [4:0]                rs1_q,
  output logic [4:0]                rs2_q,
  input  logic [31:0]               reg_v1,
  input  logic [31:0]               reg_v2,
  input  logic [ROB_ID_W-1:0]       reg_q1,
  input  logic [ROB_ID_W-1:0]       reg_q2,
  output logic [ROB_ID_W-1:0]       rob_q1,
  output logic [ROB_ID_W-1:0]       rob_q2,
  input  logic                      rob_rdy1,
  input  logic                      rob_rdy2,
  input  logic [31:0]               rob_v1,
  input  logic [31:0]               rob_v2,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*ROB_ID_W-1:0] cdb_id,
  input  logic [N_CDB*32-1:0]       cdb_data,
  output logic                      rob_ena,
  output logic [4:0]                rob_rd,
  output logic                      rob_jump,
  output logic                      rob_store,
  output logic                      rob_pred,
  output logic [31:0]               rob_pc,
  output logic [31:0]               rob_rb_pc,
  output logic                      reg_ena,
  output logic                      rs_ena,
  output logic                      lsb_ena,
  output logic [5:0]                iss_op,
  output logic [31:0]               iss_v1,
  output logic [31:0]               iss_v2,
  output logic [ROB_ID_W-1:0]       iss_q1,
  output logic [ROB_ID_W-1:0]       iss_q2,
  output logic [31:0]               iss_imm,
  output logic [31:0]               iss_pc,
  output logic [ROB_ID_W-1:0]       iss_tag
);

  localparam int QW = $clog2(QDEPTH);

  logic [31:0]         q_inst  [QDEPTH];
  logic [31:0]         q_pc    [QDEPTH];
  logic [31:0]         q_rb_pc [QDEPTH];
  logic                q_pred  [QDEPTH];
  logic [QW-1:0]       head, tail;
  logic [QW:0]         count;

  dec_t                dec;
  logic                head_lsb, target_full, stall, enq, pop;
  logic                hit1, hit2;
  logic [31:0]         v1, v2;
  logic [ROB_ID_W-1:0] q1, q2;

  assign if_ready    = (count < (QW+1)'(QDEPTH)) && !flush;
  assign enq         = if_valid && if_ready && rdy;

  assign dec         = decode(q_inst[head]);
  assign head_lsb    = is_lsb_op(dec.op);
  assign target_full = head_lsb ? lsb_full : rs_full;
  assign rs1_q       = dec.rs1;
  assign rs2_q       = dec.rs2;
  assign rob_q1      = reg_q1;
  assign rob_q2      = reg_q2;

  operand_forward #(.N_CDB(N_CDB), .ROB_ID_W(ROB_ID_W)) u_fwd1 (
    .use_src(dec.use1), .reg_q(reg_q1), .reg_v(reg_v1),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .rob_rdy(rob_rdy1), .rob_v(rob_v1), .v(v1), .q(q1), .cdb_hit(hit1)
  );

  operand_forward #(.N_CDB(N_CDB), .ROB_ID_W(ROB_ID_W)) u_fwd2 (
    .use_src(dec.use2), .reg_q(reg_q2), .reg_v(reg_v2),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .rob_rdy(rob_rdy2), .rob_v(rob_v2), .v(v2), .q(q2), .cdb_hit(hit2)
  );

  // Without bypass, a tag broadcasting this cycle holds the head one cycle so the ROB copy is read instead.
`ifdef DISPATCH_CDB_BYPASS_EN
  logic unused_hit;
  assign unused_hit = hit1 | hit2;
  assign stall      = 1'b0;
`else
  assign stall      = hit1 | hit2;
`endif

  assign pop = (count != '0) && rdy && !flush && !rob_full && !target_full && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          q_inst[tail]  <= if_inst;
          q_pc[tail]    <= if_pc;
          q_rb_pc[tail] <= if_rb_pc;
          q_pred[tail]  <= if_pred;
          tail          <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= count + (QW+1)'(enq) - (QW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_ena   <= 1'b0;
      reg_ena   <= 1'b0;
      rs_ena    <= 1'b0;
      lsb_ena   <= 1'b0;
      rob_rd    <= 5'd0;
      rob_jump  <= 1'b0;
      rob_store <= 1'b0;
      rob_pred  <= 1'b0;
      rob_pc    <= ZERO_WORD;
      rob_rb_pc <= ZERO_WORD;
      iss_op    <= NOP;
      iss_v1    <= ZERO_WORD;
      iss_v2    <= ZERO_WORD;
      iss_q1    <= ROB_ID_W'(ZERO_ROB);
      iss_q2    <= ROB_ID_W'(ZERO_ROB);
      iss_imm   <= ZERO_WORD;
      iss_pc    <= ZERO_WORD;
      iss_tag   <= ROB_ID_W'(ZERO_ROB);
    end else if (rdy) begin
      rob_ena <= 1'b0;
      reg_ena <= 1'b0;
      rs_ena  <= 1'b0;
      lsb_ena <= 1'b0;
      // NOP heads are popped silently; payload keeps the last real dispatch.
      if (pop && (dec.op != NOP)) begin
        rob_ena   <= 1'b1;
        reg_ena   <= (dec.rd != 5'd0);
        rs_ena    <= !head_lsb;
        lsb_ena   <= head_lsb;
        rob_rd    <= dec.rd;
        rob_jump  <= is_jump_op(dec.op);
        rob_store <= is_store_op(dec.op);
        rob_pred  <= q_pred[head];
        rob_pc    <= q_pc[head];
        rob_rb_pc <= q_rb_pc[head];
        iss_op    <= dec.op;
        iss_v1    <= v1;
        iss_v2    <= v2;
        iss_q1    <= q1;
        iss_q2    <= q2;
        iss_imm   <= dec.imm;
        iss_pc    <= q_pc[head];
        iss_tag   <= rob_free_id;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed-vector bench for dispatch_unit; follows DISPATCH_CDB_BYPASS_EN for the CDB case.
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  localparam int QDEPTH   = 4;
  localparam int N_CDB    = 2;
  localparam int ROB_ID_W = 4;

  logic clk = 1'b0;
  logic rst, rdy, flush, if_valid, if_ready, if_pred;
  logic [31:0] if_inst, if_pc, if_rb_pc;
  logic rob_full, rs_full, lsb_full;
  logic [ROB_ID_W-1:0] rob_free_id, reg_q1, reg_q2, rob_q1, rob_q2;
  logic [4:0] rs1_q, rs2_q;
  logic [31:0] reg_v1, reg_v2, rob_v1, rob_v2;
  logic rob_rdy1, rob_rdy2;
  logic [N_CDB-1:0] cdb_valid;
  logic [N_CDB*ROB_ID_W-1:0] cdb_id;
  logic [N_CDB*32-1:0] cdb_data;
  logic rob_ena, rob_jump, rob_store, rob_pred, reg_ena, rs_ena, lsb_ena;
  logic [4:0] rob_rd;
  logic [31:0] rob_pc, rob_rb_pc, iss_v1, iss_v2, iss_imm, iss_pc;
  logic [5:0] iss_op;
  logic [ROB_ID_W-1:0] iss_q1, iss_q2, iss_tag;

  always #5 clk = ~clk;

  dispatch_unit #(.QDEPTH(QDEPTH), .N_CDB(N_CDB), .ROB_ID_W(ROB_ID_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .if_pred(if_pred), .if_rb_pc(if_rb_pc),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_free_id(rob_free_id),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .reg_v1(reg_v1), .reg_v2(reg_v2),
    .reg_q1(reg_q1), .reg_q2(reg_q2), .rob_q1(rob_q1), .rob_q2(rob_q2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2), .rob_v1(rob_v1), .rob_v2(rob_v2),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .rob_ena(rob_ena), .rob_rd(rob_rd), .rob_jump(rob_jump), .rob_store(rob_store),
    .rob_pred(rob_pred), .rob_pc(rob_pc), .rob_rb_pc(rob_rb_pc),
    .reg_ena(reg_ena), .rs_ena(rs_ena), .lsb_ena(lsb_ena),
    .iss_op(iss_op), .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_q1(iss_q1), .iss_q2(iss_q2),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_tag(iss_tag)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  localparam logic [31:0] LW_X3  = {12'd0, 5'd1, 3'b010, 5'd3, 7'h03};
  localparam logic [31:0] SW_X2  = {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'h23};
  localparam logic [31:0] ADD_X4 = {7'd0, 5'd5, 5'd3, 3'b000, 5'd4, 7'h33};
  localparam logic [31:0] VAL_A  = 32'hAAAA_0001;
  localparam logic [31:0] VAL_B  = 32'hBBBB_0002;
  localparam logic [31:0] VAL_R  = 32'hCCCC_0003;

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_valid = 1'b0; if_inst = '0; if_pc = '0; if_pred = 1'b0; if_rb_pc = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_free_id = 4'd5;
    reg_v1 = 32'h111; reg_v2 = 32'h222; reg_q1 = '0; reg_q2 = '0;
    rob_rdy1 = 1'b0; rob_rdy2 = 1'b0; rob_v1 = '0; rob_v2 = '0;
    cdb_valid = '0; cdb_id = '0; cdb_data = '0;
    step(); step();
    chk("rst_ena", {rob_ena, reg_ena, rs_ena, lsb_ena}, 4'b0000);
    chk("rst_op", 32'(iss_op), 32'(NOP));
    chk("rst_imm", iss_imm, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(if_ready), 1);

    // ADDI x1,x0,5
    if_inst = addi(5'd1, 12'd5); if_pc = 32'h100; if_rb_pc = 32'h104; if_pred = 1'b1; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    chk("addi_early", 32'(rs_ena), 0);
    step();
    chk("addi_ena", {rob_ena, reg_ena, rs_ena, lsb_ena}, 4'b1110);
    chk("addi_op", 32'(iss_op), 32'(ADDI));
    chk("addi_q1", 32'(iss_q1), 0);
    chk("addi_v1", iss_v1, 32'h111);
    chk("addi_imm", iss_imm, 5);
    chk("addi_tag", 32'(iss_tag), 5);
    chk("addi_rd", 32'(rob_rd), 1);
    chk("addi_pc", {rob_pc, iss_pc}, {32'h100, 32'h100});
    chk("addi_rb", {rob_rb_pc[15:0], 15'd0, rob_pred}, {16'h104, 16'h1});
    step();
    chk("addi_pulse", {rob_ena, rs_ena}, 2'b00);

    // Five fetches against a full RS
    rs_full = 1'b1;
    if_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if_inst = addi(5'd2, 12'(k + 1));
      #1;
      chk($sformatf("fill_ready%0d", k), 32'(if_ready), (k < 4) ? 1 : 0);
      step();
    end
    if_valid = 1'b0;
    chk("fill_noena", 32'(rs_ena), 0);
    rs_full = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("drain_ena%0d", j), 32'(rs_ena), 1);
      chk($sformatf("drain_imm%0d", j), iss_imm, j + 1);
    end
    step();
    chk("drain_done", 32'(rs_ena), 0);

    // ADD x4,x3,x5 with both CDB channels carrying tag 3, rs2 still renamed to 7
    reg_q1 = 4'd3; reg_q2 = 4'd7; reg_v1 = 32'hDEAD;
    cdb_valid = 2'b11; cdb_id = {4'd3, 4'd3}; cdb_data = {VAL_B, VAL_A};
    if_inst = ADD_X4; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    chk("cdb_rs1q", 32'(rs1_q), 3);
    chk("cdb_robq", 32'(rob_q1), 3);
    step();
`ifdef DISPATCH_CDB_BYPASS_EN
    chk("cdb_ena", 32'(rs_ena), 1);
    chk("cdb_v1", iss_v1, VAL_A);
    chk("cdb_q1", 32'(iss_q1), 0);
    chk("cdb_q2", 32'(iss_q2), 7);
    chk("cdb_v2", iss_v2, 0);
    cdb_valid = '0;
    step();
`else
    chk("cdb_stall", 32'(rs_ena), 0);
    cdb_valid = '0; rob_rdy1 = 1'b1; rob_v1 = VAL_R;
    step();
    chk("cdb_ena", 32'(rs_ena), 1);
    chk("cdb_v1", iss_v1, VAL_R);
    chk("cdb_q1", 32'(iss_q1), 0);
    chk("cdb_q2", 32'(iss_q2), 7);
    chk("cdb_v2", iss_v2, 0);
`endif
    reg_q1 = '0; reg_q2 = '0; reg_v1 = 32'h111; rob_rdy1 = 1'b0; rob_v1 = '0;

    // LW against a full LSB, then flush
    lsb_full = 1'b1;
    if_inst = LW_X3; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    step();
    chk("lw_blocked", 32'(lsb_ena), 0);
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(if_ready), 0);
    step();
    flush = 1'b0;
    chk("flush_ena", {rob_ena, lsb_ena}, 2'b00);
    lsb_full = 1'b0;
    step();
    chk("flush_empty", 32'(lsb_ena), 0);
    if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    step();
    chk("lw_ena", {rob_ena, reg_ena, rs_ena, lsb_ena}, 4'b1101);
    chk("lw_op", 32'(iss_op), 32'(LW));

    // Illegal encoding pops as NOP
    if_inst = 32'h0; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    step();
    chk("nop_ena", {rob_ena, rs_ena, lsb_ena}, 3'b000);

    // SW x2,8(x1)
    if_inst = SW_X2; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    step();
    chk("sw_ena", {rob_ena, reg_ena, rs_ena, lsb_ena}, 4'b1001);
    chk("sw_store", {rob_store, rob_jump}, 2'b10);
    chk("sw_imm", iss_imm, 8);

    // rdy low for three cycles mid-stream
    if_inst = addi(5'd6, 12'd11); if_valid = 1'b1;
    step();
    if_inst = addi(5'd6, 12'd12);
    step();
    if_inst = addi(5'd6, 12'd13);
    chk("frz_pre", {31'd0, rs_ena}, 1);
    chk("frz_pre_imm", iss_imm, 11);
    rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("frz_ena%0d", j), 32'(rs_ena), 1);
      chk($sformatf("frz_imm%0d", j), iss_imm, 11);
    end
    if_valid = 1'b0;
    rdy = 1'b1;
    step();
    chk("frz_next", {31'd0, rs_ena}, 1);
    chk("frz_next_imm", iss_imm, 12);
    step();
    chk("frz_empty", 32'(rs_ena), 0);

    // Reset mid-stream discards buffered entries
    rs_full = 1'b1; if_inst = addi(5'd7, 12'd9); if_valid = 1'b1;
    step(); step();
    if_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; rs_full = 1'b0;
    step(); step();
    chk("rst_discard", {rob_ena, rs_ena}, 2'b00);
    chk("rst_discard_imm", iss_imm, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
